// File: rtl/bpu_pht_bimodal.sv
// Bimodal pattern history table: 2^INDEX_W two-bit saturating counters with
// registered lookup, single-cycle train RMW and a reset-time init sweep.
// Optional statistics counters are built when BPU_PHT_STATS_EN is defined.
module bpu_pht_bimodal #(
  parameter int         INDEX_W    = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pred_ready,
  input  logic               pred_valid,
  input  logic [INDEX_W-1:0] pred_idx,
  output logic               pred_resp_valid,
  output logic               pred_taken,
  output logic [1:0]         pred_state,
  input  logic               train_valid,
  input  logic [INDEX_W-1:0] train_idx,
  input  logic               train_taken,
  output logic               init_done
`ifdef BPU_PHT_STATS_EN
  ,
  output logic [15:0]        stat_train_cnt,
  output logic [15:0]        stat_flip_cnt
`endif
);

  localparam int DEPTH = 1 << INDEX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  // Handshake: a lookup is taken on any posedge where pred_valid && pred_ready;
  // its response appears one cycle later with pred_resp_valid high for exactly
  // one cycle. Trains have no back-pressure and are dropped outside RUN.
  state_t             state;
  logic [INDEX_W-1:0] sweep_idx;
  logic [1:0]         pht [DEPTH];

  logic               train_en;
  logic               lookup_en;
  logic [1:0]         train_cur;
  logic [1:0]         train_next;
  logic [1:0]         lookup_val;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx;
  logic [1:0]         wr_data;

  always_comb begin
    train_en  = train_valid && (state == S_RUN);
    lookup_en = pred_valid && pred_ready;
    train_cur = pht[train_idx];
    if (train_taken) train_next = (train_cur == 2'b11) ? 2'b11 : train_cur + 2'd1;
    else             train_next = (train_cur == 2'b00) ? 2'b00 : train_cur - 2'd1;
    // Write-first: a same-index train in the same cycle is visible to the lookup.
    lookup_val = (train_en && (train_idx == pred_idx)) ? train_next : pht[pred_idx];
    if (state == S_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_idx;
      wr_data = INIT_STATE;
    end else begin
      wr_en   = train_en;
      wr_idx  = train_idx;
      wr_data = train_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) pht[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_INIT;
      sweep_idx       <= '0;
      pred_ready      <= 1'b0;
      init_done       <= 1'b0;
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
      pred_state      <= 2'b00;
    end else begin
      case (state)
        S_INIT: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == INDEX_W'(DEPTH - 1)) begin
            state      <= S_RUN;
            pred_ready <= 1'b1;
            init_done  <= 1'b1;
          end
        end
        default: begin
          state <= S_RUN;
        end
      endcase
      pred_resp_valid <= lookup_en;
      if (lookup_en) begin
        pred_state <= lookup_val;
        pred_taken <= lookup_val[1];
      end
    end
  end

`ifdef BPU_PHT_STATS_EN
  // A flip is any update that moves the counter across the WNT/WT boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_train_cnt <= '0;
      stat_flip_cnt  <= '0;
    end else if (train_en) begin
      if (stat_train_cnt != 16'hFFFF) stat_train_cnt <= stat_train_cnt + 16'd1;
      if ((train_cur[1] != train_next[1]) && (stat_flip_cnt != 16'hFFFF))
        stat_flip_cnt <= stat_flip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_pht_bimodal.sv
// Directed self-checking bench for bpu_pht_bimodal (INDEX_W=6, INIT_STATE=01).
// Stats checks are compiled in when BPU_PHT_STATS_EN is defined.
module tb_bpu_pht_bimodal;

  localparam int INDEX_W = 6;
  localparam int DEPTH   = 1 << INDEX_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pred_ready;
  logic               pred_valid;
  logic [INDEX_W-1:0] pred_idx;
  logic               pred_resp_valid;
  logic               pred_taken;
  logic [1:0]         pred_state;
  logic               train_valid;
  logic [INDEX_W-1:0] train_idx;
  logic               train_taken;
  logic               init_done;
`ifdef BPU_PHT_STATS_EN
  logic [15:0]        stat_train_cnt;
  logic [15:0]        stat_flip_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  bpu_pht_bimodal #(.INDEX_W(INDEX_W), .INIT_STATE(2'b01)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_ready      (pred_ready),
    .pred_valid      (pred_valid),
    .pred_idx        (pred_idx),
    .pred_resp_valid (pred_resp_valid),
    .pred_taken      (pred_taken),
    .pred_state      (pred_state),
    .train_valid     (train_valid),
    .train_idx       (train_idx),
    .train_taken     (train_taken),
    .init_done       (init_done)
`ifdef BPU_PHT_STATS_EN
    ,
    .stat_train_cnt  (stat_train_cnt),
    .stat_flip_cnt   (stat_flip_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(pred_ready),      32'd0);
    check({tag, "_done"},   32'(init_done),       32'd0);
    check({tag, "_rvalid"}, 32'(pred_resp_valid), 32'd0);
    check({tag, "_taken"},  32'(pred_taken),      32'd0);
    check({tag, "_state"},  32'(pred_state),      32'd0);
  endtask

  // Driver tasks
  task automatic do_train(input int idx, input logic t);
    train_valid = 1'b1;
    train_idx   = INDEX_W'(idx);
    train_taken = t;
    step();
    train_valid = 1'b0;
  endtask

  task automatic do_lookup_check(input string tag, input int idx, input logic [1:0] exp);
    pred_valid = 1'b1;
    pred_idx   = INDEX_W'(idx);
    step();
    pred_valid = 1'b0;
    check({tag, "_rvalid"}, 32'(pred_resp_valid), 32'd1);
    check({tag, "_state"},  32'(pred_state),      32'(exp));
    check({tag, "_taken"},  32'(pred_taken),      32'(exp[1]));
  endtask

  // Counts 64 cycles of pred_ready low (no responses) then checks the rise.
  task automatic check_sweep(input string tag, input bit drop_pulse);
    for (int i = 0; i < DEPTH; i++) begin
      check({tag, "_ready_low"}, 32'(pred_ready), 32'd0);
      check({tag, "_no_resp"},   32'(pred_resp_valid), 32'd0);
      if (drop_pulse && i == 10) begin
        train_valid = 1'b1; train_idx = 6'd3; train_taken = 1'b1;
        pred_valid  = 1'b1; pred_idx  = 6'd3;
      end
      step();
      train_valid = 1'b0;
      pred_valid  = 1'b0;
    end
    check({tag, "_ready_high"}, 32'(pred_ready), 32'd1);
    check({tag, "_init_done"},  32'(init_done),  32'd1);
    check({tag, "_no_resp_end"}, 32'(pred_resp_valid), 32'd0);
  endtask

  logic [1:0] exp_up [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
  logic [1:0] exp_dn [5] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};

  initial begin
    rst_n = 1'b0; pred_valid = 1'b0; pred_idx = '0;
    train_valid = 1'b0; train_idx = '0; train_taken = 1'b0;
    step();
    step();
    check_reset_outputs("rst");

    // Init sweep with a dropped train/lookup pulse in the middle
    rst_n = 1'b1;
    check_sweep("sweep", 1'b1);

`ifdef BPU_PHT_STATS_EN
    check("stat_train_init", 32'(stat_train_cnt), 32'd0);
    check("stat_flip_init",  32'(stat_flip_cnt),  32'd0);
`endif

    // Back-to-back lookups over the whole table (idx 3 proves the drop)
    for (int i = 0; i < DEPTH; i++) begin
      pred_valid = 1'b1;
      pred_idx   = INDEX_W'(i);
      step();
      check("init_rvalid", 32'(pred_resp_valid), 32'd1);
      check("init_state",  32'(pred_state),      32'd1);
      check("init_taken",  32'(pred_taken),      32'd0);
    end
    pred_valid = 1'b0;
    step();
    check("idle_rvalid", 32'(pred_resp_valid), 32'd0);
    check("hold_state",  32'(pred_state),      32'd1);

`ifdef BPU_PHT_STATS_EN
    do_train(2, 1'b1);
    do_train(2, 1'b1);
    do_train(2, 1'b0);
    do_train(2, 1'b0);
    check("stat_train", 32'(stat_train_cnt), 32'd4);
    check("stat_flip",  32'(stat_flip_cnt),  32'd2);
`endif

    // Saturation up and down on idx 5
    for (int k = 0; k < 4; k++) begin
      do_train(5, 1'b1);
      do_lookup_check("sat_up", 5, exp_up[k]);
    end
    for (int k = 0; k < 5; k++) begin
      do_train(5, 1'b0);
      do_lookup_check("sat_dn", 5, exp_dn[k]);
    end

    // Write-first forwarding, same index
    train_valid = 1'b1; train_idx = 6'd9; train_taken = 1'b1;
    pred_valid  = 1'b1; pred_idx  = 6'd9;
    step();
    train_valid = 1'b0; pred_valid = 1'b0;
    check("fwd_state", 32'(pred_state), 32'd2);
    check("fwd_taken", 32'(pred_taken), 32'd1);

    // Independent indices in the same cycle
    train_valid = 1'b1; train_idx = 6'd9; train_taken = 1'b1;
    pred_valid  = 1'b1; pred_idx  = 6'd10;
    step();
    train_valid = 1'b0; pred_valid = 1'b0;
    check("indep_state", 32'(pred_state), 32'd1);
    check("indep_taken", 32'(pred_taken), 32'd0);
    do_lookup_check("indep_9", 9, 2'b11);

    // Mid-operation reset
    do_train(7, 1'b1);
    do_train(7, 1'b1);
    do_lookup_check("pre_rst_7", 7, 2'b11);
    pred_valid  = 1'b1; pred_idx  = 6'd7;
    train_valid = 1'b1; train_idx = 6'd7; train_taken = 1'b0;
    rst_n = 1'b0;
    step();
    pred_valid = 1'b0; train_valid = 1'b0;
    check_reset_outputs("mid_rst");
`ifdef BPU_PHT_STATS_EN
    check("stat_train_rst", 32'(stat_train_cnt), 32'd0);
    check("stat_flip_rst",  32'(stat_flip_cnt),  32'd0);
`endif
    rst_n = 1'b1;
    check_sweep("resweep", 1'b0);
    do_lookup_check("post_rst_7", 7, 2'b01);
    do_lookup_check("post_rst_5", 5, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
